// File: rtl/axi4_read_master.sv
// AXI4 read master: accepts one burst command at a time, issues the AR
// request, streams R beats straight through to the consumer and reports
// completion with a one-cycle done pulse plus error status.
module axi4_read_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  // read data to consumer
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  // completion
  output logic                  done,
  output logic                  err,
  // AXI AR channel
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  // AXI R channel
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam int unsigned SZ = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                state_q,  state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q,  arlen_d;
  logic [7:0]            cnt_q,    cnt_d;
  logic                  sticky_q, sticky_d;

  logic [13:0]           end_off;
  logic                  illegal;

  // Command legality: misaligned start, or last beat crossing the 4 KB page.
  always_comb begin
    end_off = 14'(cmd_addr[11:0]) + (14'(cmd_len) << SZ);
    illegal = (|cmd_addr[SZ-1:0]) || (end_off > 14'hFFF);
  end

  // State and datapath registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= IDLE;
      araddr_q <= '0;
      arlen_q  <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  // Next-state and datapath update; burst ends on the beat counter alone.
  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (illegal) begin
            state_d  = RESP;
            sticky_d = 1'b1;
          end else begin
            state_d  = ADDR;
            araddr_d = cmd_addr;
            arlen_d  = cmd_len;
            cnt_d    = cmd_len;
            sticky_d = 1'b0;
          end
        end
      end
      ADDR: begin
        if (ARREADY) state_d = DATA;
      end
      DATA: begin
        if (RVALID && rd_ready) begin
          if ((RRESP != 2'b00) || (RLAST != (cnt_q == 8'd0))) sticky_d = 1'b1;
          if (cnt_q == 8'd0) state_d = RESP;
          else               cnt_d   = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d  = IDLE;
        sticky_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; R channel is a zero-latency pass-through in DATA.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    ARVALID   = (state_q == ADDR);
    ARADDR    = araddr_q;
    ARLEN     = arlen_q;
    ARSIZE    = 3'(SZ);
    RREADY    = (state_q == DATA) && rd_ready;
    rd_valid  = (state_q == DATA) && RVALID;
    rd_last   = (state_q == DATA) && RLAST;
    rd_data   = RDATA;
    done      = (state_q == RESP);
    err       = (state_q == RESP) && sticky_q;
  end

endmodule
